fpu_issue_rob: RTL and testbench
================================

Name: fpu_issue_rob

Overview:
- Initiator-side companion to the CVFPU wrapper: sits between a lane-group issue stage and the FPU request/response ports.
- Allocates a FPU tag per request, equal to the reorder-buffer slot index, and forwards the request to the FPU.
- Captures FPU responses, which may return out of order across ADDMUL/NONCOMP/CONV/DIVSQRT pipelines, and retires them strictly in issue order with the caller's id restored.

Parameters:
- WIDTH, 512, operand/result width in bits.
- TAG_WIDTH, 3, FPU tag width; DEPTH = 2^TAG_WIDTH ROB entries.
- ID_WIDTH, 8, opaque caller id carried from issue to retirement.

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high reset
- in_valid / in_ready  in / out  1 / 1  issue handshake
- in_bits_operands_0/1/2  in  WIDTH each  operands
- in_bits_op  in  5  FPU op, op_mod in LSB
- in_bits_roundingMode  in  3
- in_bits_srcFormat / in_bits_dstFormat  in  3 each
- in_bits_intFormat  in  2
- in_bits_simdMask  in  16
- in_bits_id  in  ID_WIDTH  caller id
- flush  in  1  kill everything in flight
- fpu_req_valid / fpu_req_ready  out / in  1 / 1
- fpu_req_bits_*  out  same widths as the in_bits_* fields except id  forwarded request
- fpu_req_bits_tag  out  TAG_WIDTH  allocated slot
- fpu_flush  out  1
- fpu_resp_valid / fpu_resp_ready  in / out  1 / 1
- fpu_resp_bits_result  in  WIDTH
- fpu_resp_bits_status  in  5
- fpu_resp_bits_tag  in  TAG_WIDTH
- out_valid / out_ready  out / in  1 / 1  in-order retirement handshake
- out_bits_result  out  WIDTH
- out_bits_status  out  5
- out_bits_id  out  ID_WIDTH
- busy  out  1  count != 0
- err_unexpected  out  1  sticky protocol error

Behaviour:
- **State:**
  - Per entry: alloc, done, id, result, status.
  - Global: head, tail (TAG_WIDTH, wrap mod DEPTH) and count (TAG_WIDTH+1).
- **Reset:**
  - All alloc/done = 0; head = tail = count = 0; err_unexpected = 0.
  - Outputs: out_valid = 0, busy = 0, fpu_flush = 0.
  - While reset is high: in_ready = 0 and fpu_req_valid = 0.
  - A reset in the middle of operation discards all entries; the FPU is reset by the same reset.
- **Issue path (combinational pass-through, zero latency):**
  - full = (count == DEPTH).
  - fpu_req_valid = in_valid & ~full & ~flush.
  - in_ready = fpu_req_ready & ~full & ~flush.
  - fpu_req_bits_* = in_bits_*; fpu_req_bits_tag = tail.
  - Issue fires when in_valid & in_ready. On fire: entry[tail].alloc <= 1, done <= 0, id <= in_bits_id; tail <= tail+1.
- **Response path:**
  - fpu_resp_ready = 1 constantly; a slot is always reserved for every in-flight tag.
  - On fpu_resp_valid, when entry[tag].alloc & ~done: done <= 1; result and status are written.
  - When the tag is not allocated, or is already done: the write is dropped and err_unexpected <= 1 (sticky until reset).
- **Retire path:**
  - out_valid = entry[head].alloc & entry[head].done; out_bits_* are read from entry[head].
  - On out fire: alloc <= 0, done <= 0, head <= head+1.
  - Minimum latency from FPU response to out_valid is 1 cycle, because storage is registered.
  - A response for the head entry and out_ready in the same cycle does not retire that cycle.
- **Count:**
  - +1 on issue fire, −1 on retire fire; unchanged when both fire.
  - Issue into a slot freed in the same cycle is legal only if count < DEPTH before the update. No issue at full, even when retiring the same cycle.
- **Out-of-order:**
  - A younger response may complete first; it waits until every older entry has retired.
  - Head-of-line blocking is by design.
- **Flush:**
  - fpu_flush = flush (combinational).
  - Next cycle: all alloc/done = 0, head = tail = count = 0; out_valid is low in the cycle after flush.
  - Issue and retire are blocked in the flush cycle (out_valid forced 0).
  - Responses arriving in the flush cycle are dropped without raising err_unexpected.
- **busy:** high whenever count != 0; it does not reflect the FPU's own busy.

Test Plan:
- **Reset, single op:** reset, then issue id=0x11, op=ADD, ops 1.0/2.0 fp32 lanes. Expect fpu_req_bits_tag=0. FPU responds tag 0, result 3.0 per lane, status 0. Expect out_valid exactly 1 cycle later with id=0x11 and result 3.0 lanes; busy falls after retire.
- **Out-of-order:** issue ids A,B,C (tags 0,1,2); respond tags 2, 0, 1 on consecutive cycles. Expect retirement order A,B,C with matching results, and out_valid low until the tag-0 response is captured.
- **Full and wrap:** with DEPTH=8 and responses withheld, issue 8 ops. Expect in_ready=0 and fpu_req_valid=0 with in_valid held. Respond and retire one; in_ready rises; the next issue gets tag 0 (wrap).
- **Simultaneous issue and retire at count=5:** count stays 5, head and tail each advance by 1, and the tags stay consistent.
- **Flush:** with 4 entries in flight (2 done), assert flush for 1 cycle. Expect fpu_flush=1, out_valid=0, and busy=0 the next cycle. A tag-3 response in the flush cycle must not set err_unexpected. A new issue then gets tag 0.
- **Protocol error:** response with an unallocated tag 5 at count=0. Expect err_unexpected=1 sticky, no out_valid, and it is cleared only by reset.

Source files
------------

// File: rtl/fpu_issue_rob.sv
// Issue-side reorder buffer for the CVFPU: tags each request with its ROB slot,
// captures out-of-order FPU responses and retires them in issue order.
module fpu_issue_rob #(
  parameter int WIDTH     = 512,
  parameter int TAG_WIDTH = 3,
  parameter int ID_WIDTH  = 8
) (
  input  logic                 clock,
  input  logic                 reset,

  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_bits_operands_0,
  input  logic [WIDTH-1:0]     in_bits_operands_1,
  input  logic [WIDTH-1:0]     in_bits_operands_2,
  input  logic [4:0]           in_bits_op,
  input  logic [2:0]           in_bits_roundingMode,
  input  logic [2:0]           in_bits_srcFormat,
  input  logic [2:0]           in_bits_dstFormat,
  input  logic [1:0]           in_bits_intFormat,
  input  logic [15:0]          in_bits_simdMask,
  input  logic [ID_WIDTH-1:0]  in_bits_id,
  input  logic                 flush,

  output logic                 fpu_req_valid,
  input  logic                 fpu_req_ready,
  output logic [WIDTH-1:0]     fpu_req_bits_operands_0,
  output logic [WIDTH-1:0]     fpu_req_bits_operands_1,
  output logic [WIDTH-1:0]     fpu_req_bits_operands_2,
  output logic [4:0]           fpu_req_bits_op,
  output logic [2:0]           fpu_req_bits_roundingMode,
  output logic [2:0]           fpu_req_bits_srcFormat,
  output logic [2:0]           fpu_req_bits_dstFormat,
  output logic [1:0]           fpu_req_bits_intFormat,
  output logic [15:0]          fpu_req_bits_simdMask,
  output logic [TAG_WIDTH-1:0] fpu_req_bits_tag,
  output logic                 fpu_flush,

  input  logic                 fpu_resp_valid,
  output logic                 fpu_resp_ready,
  input  logic [WIDTH-1:0]     fpu_resp_bits_result,
  input  logic [4:0]           fpu_resp_bits_status,
  input  logic [TAG_WIDTH-1:0] fpu_resp_bits_tag,

  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_bits_result,
  output logic [4:0]           out_bits_status,
  output logic [ID_WIDTH-1:0]  out_bits_id,

  output logic                 busy,
  output logic                 err_unexpected
);

  localparam int DEPTH = 1 << TAG_WIDTH;
  localparam logic [TAG_WIDTH:0] DEPTH_CNT = (TAG_WIDTH + 1)'(DEPTH);

  logic [DEPTH-1:0]     alloc;
  logic [DEPTH-1:0]     done;
  logic [ID_WIDTH-1:0]  id_mem     [DEPTH];
  logic [WIDTH-1:0]     result_mem [DEPTH];
  logic [4:0]           status_mem [DEPTH];

  logic [TAG_WIDTH-1:0] head;
  logic [TAG_WIDTH-1:0] tail;
  logic [TAG_WIDTH:0]   count;

  logic full;
  logic issue_fire;
  logic retire_fire;
  logic resp_ok;
  logic resp_bad;

  assign full = (count == DEPTH_CNT);

  // Issue path: zero-latency pass-through, tag is the slot about to be filled.
  assign in_ready      = fpu_req_ready & ~full & ~flush & ~reset;
  assign fpu_req_valid = in_valid & ~full & ~flush & ~reset;
  assign issue_fire    = in_valid & in_ready;

  assign fpu_req_bits_operands_0   = in_bits_operands_0;
  assign fpu_req_bits_operands_1   = in_bits_operands_1;
  assign fpu_req_bits_operands_2   = in_bits_operands_2;
  assign fpu_req_bits_op           = in_bits_op;
  assign fpu_req_bits_roundingMode = in_bits_roundingMode;
  assign fpu_req_bits_srcFormat    = in_bits_srcFormat;
  assign fpu_req_bits_dstFormat    = in_bits_dstFormat;
  assign fpu_req_bits_intFormat    = in_bits_intFormat;
  assign fpu_req_bits_simdMask     = in_bits_simdMask;
  assign fpu_req_bits_tag          = tail;
  assign fpu_flush                 = flush;

  // Every in-flight tag owns a slot, so responses never need backpressure.
  assign fpu_resp_ready = 1'b1;
  assign resp_ok  = fpu_resp_valid & alloc[fpu_resp_bits_tag] & ~done[fpu_resp_bits_tag];
  assign resp_bad = fpu_resp_valid & ~resp_ok;

  assign out_valid       = alloc[head] & done[head] & ~flush & ~reset;
  assign retire_fire     = out_valid & out_ready;
  assign out_bits_result = result_mem[head];
  assign out_bits_status = status_mem[head];
  assign out_bits_id     = id_mem[head];

  assign busy = (count != '0);

  // Issue and retire can never hit the same slot in one cycle: head == tail
  // only when empty (nothing to retire) or full (nothing may issue).
  always_ff @(posedge clock) begin
    if (reset) begin
      alloc          <= '0;
      done           <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      err_unexpected <= 1'b0;
    end else if (flush) begin
      // Responses landing in the flush cycle belong to killed work: no error.
      alloc <= '0;
      done  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (resp_ok)  done[fpu_resp_bits_tag] <= 1'b1;
      if (resp_bad) err_unexpected <= 1'b1;
      if (retire_fire) begin
        alloc[head] <= 1'b0;
        done[head]  <= 1'b0;
        head        <= head + 1'b1;
      end
      if (issue_fire) begin
        alloc[tail] <= 1'b1;
        done[tail]  <= 1'b0;
        tail        <= tail + 1'b1;
      end
      unique case ({issue_fire, retire_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage has no reset; alloc/done qualify every read, so
  // stale contents are never observed and the wide arrays stay reset-free.
  always_ff @(posedge clock) begin
    if (issue_fire) id_mem[tail] <= in_bits_id;
    if (resp_ok) begin
      result_mem[fpu_resp_bits_tag] <= fpu_resp_bits_result;
      status_mem[fpu_resp_bits_tag] <= fpu_resp_bits_status;
    end
  end

endmodule

// File: tb/tb_fpu_issue_rob.sv
// Self-checking bench for fpu_issue_rob: directed scenarios plus randomized
// traffic against an issue-order queue model of the reorder buffer.
module tb_fpu_issue_rob;

  localparam int WIDTH = 512;
  localparam int TW    = 3;
  localparam int IW    = 8;
  localparam int DEPTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_bits_operands_0, in_bits_operands_1, in_bits_operands_2;
  logic [4:0]       in_bits_op;
  logic [2:0]       in_bits_roundingMode, in_bits_srcFormat, in_bits_dstFormat;
  logic [1:0]       in_bits_intFormat;
  logic [15:0]      in_bits_simdMask;
  logic [IW-1:0]    in_bits_id;
  logic             flush;
  logic             fpu_req_valid, fpu_req_ready;
  logic [WIDTH-1:0] fpu_req_bits_operands_0, fpu_req_bits_operands_1, fpu_req_bits_operands_2;
  logic [4:0]       fpu_req_bits_op;
  logic [2:0]       fpu_req_bits_roundingMode, fpu_req_bits_srcFormat, fpu_req_bits_dstFormat;
  logic [1:0]       fpu_req_bits_intFormat;
  logic [15:0]      fpu_req_bits_simdMask;
  logic [TW-1:0]    fpu_req_bits_tag;
  logic             fpu_flush;
  logic             fpu_resp_valid, fpu_resp_ready;
  logic [WIDTH-1:0] fpu_resp_bits_result;
  logic [4:0]       fpu_resp_bits_status;
  logic [TW-1:0]    fpu_resp_bits_tag;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_bits_result;
  logic [4:0]       out_bits_status;
  logic [IW-1:0]    out_bits_id;
  logic             busy, err_unexpected;

  int checks = 0;
  int errors = 0;

  fpu_issue_rob #(.WIDTH(WIDTH), .TAG_WIDTH(TW), .ID_WIDTH(IW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_bits_operands_0(in_bits_operands_0), .in_bits_operands_1(in_bits_operands_1),
    .in_bits_operands_2(in_bits_operands_2), .in_bits_op(in_bits_op),
    .in_bits_roundingMode(in_bits_roundingMode), .in_bits_srcFormat(in_bits_srcFormat),
    .in_bits_dstFormat(in_bits_dstFormat), .in_bits_intFormat(in_bits_intFormat),
    .in_bits_simdMask(in_bits_simdMask), .in_bits_id(in_bits_id), .flush(flush),
    .fpu_req_valid(fpu_req_valid), .fpu_req_ready(fpu_req_ready),
    .fpu_req_bits_operands_0(fpu_req_bits_operands_0), .fpu_req_bits_operands_1(fpu_req_bits_operands_1),
    .fpu_req_bits_operands_2(fpu_req_bits_operands_2), .fpu_req_bits_op(fpu_req_bits_op),
    .fpu_req_bits_roundingMode(fpu_req_bits_roundingMode), .fpu_req_bits_srcFormat(fpu_req_bits_srcFormat),
    .fpu_req_bits_dstFormat(fpu_req_bits_dstFormat), .fpu_req_bits_intFormat(fpu_req_bits_intFormat),
    .fpu_req_bits_simdMask(fpu_req_bits_simdMask), .fpu_req_bits_tag(fpu_req_bits_tag),
    .fpu_flush(fpu_flush),
    .fpu_resp_valid(fpu_resp_valid), .fpu_resp_ready(fpu_resp_ready),
    .fpu_resp_bits_result(fpu_resp_bits_result), .fpu_resp_bits_status(fpu_resp_bits_status),
    .fpu_resp_bits_tag(fpu_resp_bits_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits_result(out_bits_result),
    .out_bits_status(out_bits_status), .out_bits_id(out_bits_id),
    .busy(busy), .err_unexpected(err_unexpected)
  );

  always #5 clock = ~clock;

  // Reference model: in-flight operations in issue order.
  typedef struct {
    logic [TW-1:0]    tag;
    logic [IW-1:0]    id;
    bit               done;
    logic [WIDTH-1:0] result;
    logic [4:0]       status;
  } rob_entry_t;

  rob_entry_t q[$];
  int         next_tag = 0;
  bit         m_err = 0;

  function automatic bit m_in_ready();
    return !reset && fpu_req_ready && (q.size() < DEPTH) && !flush;
  endfunction

  function automatic bit m_req_valid();
    return !reset && in_valid && (q.size() < DEPTH) && !flush;
  endfunction

  function automatic bit m_out_valid();
    return !reset && !flush && (q.size() > 0) && q[0].done;
  endfunction

  function automatic logic [WIDTH-1:0] lanes(input logic [31:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rand_wide();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Advance one clock and apply the model's view of what fired in that cycle.
  task automatic tick();
    bit         issue, retire;
    int         idx;
    rob_entry_t e;
    issue  = in_valid && m_in_ready();
    retire = m_out_valid() && out_ready;
    @(posedge clock);
    if (reset) begin
      q.delete(); next_tag = 0; m_err = 0;
    end else if (flush) begin
      q.delete(); next_tag = 0;
    end else begin
      if (fpu_resp_valid) begin
        idx = -1;
        foreach (q[i]) if (q[i].tag == fpu_resp_bits_tag) idx = i;
        if (idx >= 0 && !q[idx].done) begin
          e = q[idx]; e.done = 1; e.result = fpu_resp_bits_result; e.status = fpu_resp_bits_status;
          q[idx] = e;
        end else m_err = 1;
      end
      if (retire) void'(q.pop_front());
      if (issue) begin
        e.tag = TW'(next_tag); e.id = in_bits_id; e.done = 0; e.result = '0; e.status = '0;
        q.push_back(e);
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    in_valid = 0; fpu_resp_valid = 0; out_ready = 0; flush = 0; fpu_req_ready = 1;
    in_bits_operands_0 = '0; in_bits_operands_1 = '0; in_bits_operands_2 = '0;
    in_bits_op = '0; in_bits_roundingMode = '0; in_bits_srcFormat = '0; in_bits_dstFormat = '0;
    in_bits_intFormat = '0; in_bits_simdMask = '0; in_bits_id = '0;
    fpu_resp_bits_result = '0; fpu_resp_bits_status = '0; fpu_resp_bits_tag = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic issue_ops(input int n, input logic [IW-1:0] base_id);
    for (int i = 0; i < n; i++) begin
      in_valid = 1; in_bits_id = base_id + IW'(i); #1;
      checks++; if (fpu_req_bits_tag !== TW'(next_tag)) begin errors++; $display("FAIL issue_tag: got %0d expected %0d", fpu_req_bits_tag, next_tag); end
      tick();
    end
    in_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; in_valid = 1; in_bits_id = 8'h55; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++; if (fpu_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %0b expected 0", fpu_req_valid); end
    tick(); tick();
    reset = 0; in_valid = 0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err_unexpected); end
    checks++; if (fpu_flush !== 1'b0) begin errors++; $display("FAIL reset_fpu_flush: got %0b expected 0", fpu_flush); end
    checks++; if (fpu_resp_ready !== 1'b1) begin errors++; $display("FAIL resp_ready: got %0b expected 1", fpu_resp_ready); end
  endtask

  task automatic test_single_op();
    in_valid = 1; in_bits_id = 8'h11; in_bits_op = 5'b00100;
    in_bits_operands_0 = lanes(32'h3F80_0000); in_bits_operands_1 = lanes(32'h4000_0000);
    in_bits_simdMask = 16'hFFFF; in_bits_roundingMode = 3'd1; in_bits_dstFormat = 3'd2; in_bits_intFormat = 2'd3; #1;
    checks++; if (fpu_req_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL single_handshake: got %0b/%0b expected 1/1", fpu_req_valid, in_ready); end
    checks++; if (fpu_req_bits_tag !== 3'd0) begin errors++; $display("FAIL single_tag: got %0d expected 0", fpu_req_bits_tag); end
    checks++; if (fpu_req_bits_op !== 5'b00100 || fpu_req_bits_simdMask !== 16'hFFFF || fpu_req_bits_roundingMode !== 3'd1
                  || fpu_req_bits_dstFormat !== 3'd2 || fpu_req_bits_intFormat !== 2'd3)
      begin errors++; $display("FAIL single_fields: got op %0h mask %0h rm %0d dst %0d int %0d", fpu_req_bits_op, fpu_req_bits_simdMask,
                               fpu_req_bits_roundingMode, fpu_req_bits_dstFormat, fpu_req_bits_intFormat); end
    checks++; if (fpu_req_bits_operands_1 !== lanes(32'h4000_0000) || fpu_req_bits_operands_0 !== lanes(32'h3F80_0000))
      begin errors++; $display("FAIL single_operands: got %0h expected 2.0 lanes", fpu_req_bits_operands_1[31:0]); end
    tick();
    in_valid = 0; #1;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL single_pending: got busy %0b out_valid %0b expected 1/0", busy, out_valid); end
    fpu_resp_valid = 1; fpu_resp_bits_tag = 0; fpu_resp_bits_result = lanes(32'h4040_0000); fpu_resp_bits_status = 0; out_ready = 1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_same_cycle: got %0b expected 0", out_valid); end
    tick();
    fpu_resp_valid = 0; #1;
    checks++; if (out_valid !== 1'b1 || out_bits_id !== 8'h11) begin errors++; $display("FAIL single_retire: got valid %0b id %0h expected 1/11", out_valid, out_bits_id); end
    checks++; if (out_bits_result !== lanes(32'h4040_0000) || out_bits_status !== 5'd0) begin errors++; $display("FAIL single_result: got %0h expected 3.0 lanes", out_bits_result[31:0]); end
    tick();
    out_ready = 0; #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_done: got busy %0b out_valid %0b expected 0/0", busy, out_valid); end
  endtask

  task automatic test_out_of_order();
    int            order [3] = '{2, 0, 1};
    logic [IW-1:0] got[$];
    do_reset();
    issue_ops(3, 8'hA0);
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      fpu_resp_valid = 1; fpu_resp_bits_tag = TW'(order[k]);
      fpu_resp_bits_result = lanes(32'h1000 + 32'(order[k])); fpu_resp_bits_status = 5'(order[k]); #1;
      checks++; if (out_valid !== m_out_valid()) begin errors++; $display("FAIL ooo_valid: got %0b expected %0b", out_valid, m_out_valid()); end
      if (k < 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ooo_hol: got %0b expected 0 at step %0d", out_valid, k); end
      end
      if (out_valid) begin
        got.push_back(out_bits_id);
        checks++; if (out_bits_result !== q[0].result) begin errors++; $display("FAIL ooo_result: got %0h expected %0h", out_bits_result[31:0], q[0].result[31:0]); end
      end
      tick();
    end
    fpu_resp_valid = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) begin
        got.push_back(out_bits_id);
        checks++; if (out_bits_result !== q[0].result || out_bits_status !== q[0].status)
          begin errors++; $display("FAIL ooo_drain_result: got %0h/%0d expected %0h/%0d", out_bits_result[31:0], out_bits_status, q[0].result[31:0], q[0].status); end
      end
      tick();
    end
    out_ready = 0;
    checks++; if (got.size() != 3) begin errors++; $display("FAIL ooo_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== 8'hA0 + IW'(i)) begin errors++; $display("FAIL ooo_order: got %0h expected %0h", got[i], 8'hA0 + IW'(i)); end
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    issue_ops(DEPTH, 8'h30);
    in_valid = 1; in_bits_id = 8'h40; #1;
    checks++; if (in_ready !== 1'b0 || fpu_req_valid !== 1'b0) begin errors++; $display("FAIL full_block: got %0b/%0b expected 0/0", in_ready, fpu_req_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %0b expected 1", busy); end
    tick();
    fpu_resp_valid = 1; fpu_resp_bits_tag = 0; fpu_resp_bits_result = lanes(32'hBEEF); #1;
    tick();
    fpu_resp_valid = 0; out_ready = 1; #1;
    checks++; if (out_valid !== 1'b1 || out_bits_id !== 8'h30) begin errors++; $display("FAIL full_retire: got %0b id %0h expected 1/30", out_valid, out_bits_id); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_no_issue_on_retire: got %0b expected 0", in_ready); end
    tick();
    out_ready = 0; #1;
    checks++; if (in_ready !== 1'b1 || fpu_req_valid !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %0b/%0b expected 1/1", in_ready, fpu_req_valid); end
    checks++; if (fpu_req_bits_tag !== 3'd0) begin errors++; $display("FAIL wrap_tag: got %0d expected 0", fpu_req_bits_tag); end
    tick();
    in_valid = 0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL refull: got %0b expected 0", in_ready); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue_ops(5, 8'h50);
    fpu_resp_valid = 1; fpu_resp_bits_tag = 0; fpu_resp_bits_result = lanes(32'h50); tick();
    fpu_resp_valid = 0; in_valid = 1; in_bits_id = 8'h55; out_ready = 1; #1;
    checks++; if (out_valid !== 1'b1 || out_bits_id !== 8'h50) begin errors++; $display("FAIL b2b_retire: got %0b id %0h expected 1/50", out_valid, out_bits_id); end
    checks++; if (in_ready !== 1'b1 || fpu_req_bits_tag !== 3'd5) begin errors++; $display("FAIL b2b_issue: got ready %0b tag %0d expected 1/5", in_ready, fpu_req_bits_tag); end
    tick();
    in_valid = 0; out_ready = 0;
    fpu_resp_valid = 1; fpu_resp_bits_tag = 1; fpu_resp_bits_result = lanes(32'h51); tick();
    fpu_resp_valid = 0; in_valid = 1; in_bits_id = 8'h56; out_ready = 1; #1;
    checks++; if (out_valid !== 1'b1 || out_bits_id !== 8'h51 || out_bits_result !== lanes(32'h51))
      begin errors++; $display("FAIL b2b_head: got %0b id %0h expected 1/51", out_valid, out_bits_id); end
    checks++; if (fpu_req_bits_tag !== 3'd6 || busy !== 1'b1) begin errors++; $display("FAIL b2b_tail: got tag %0d busy %0b expected 6/1", fpu_req_bits_tag, busy); end
    tick();
    in_valid = 0; out_ready = 0;
  endtask

  task automatic test_flush();
    do_reset();
    issue_ops(4, 8'h60);
    fpu_resp_valid = 1; fpu_resp_bits_tag = 0; tick();
    fpu_resp_bits_tag = 1; tick();
    fpu_resp_valid = 0; #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got %0b expected 1", out_valid); end
    flush = 1; fpu_resp_valid = 1; fpu_resp_bits_tag = 3; in_valid = 1; in_bits_id = 8'h70; out_ready = 1; #1;
    checks++; if (fpu_flush !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle: got fpu_flush %0b out_valid %0b expected 1/0", fpu_flush, out_valid); end
    checks++; if (in_ready !== 1'b0 || fpu_req_valid !== 1'b0) begin errors++; $display("FAIL flush_issue_block: got %0b/%0b expected 0/0", in_ready, fpu_req_valid); end
    tick();
    flush = 0; fpu_resp_valid = 0; out_ready = 0; #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_after: got busy %0b out_valid %0b expected 0/0", busy, out_valid); end
    checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL flush_no_err: got %0b expected 0", err_unexpected); end
    checks++; if (fpu_req_bits_tag !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_new_tag: got %0d ready %0b expected 0/1", fpu_req_bits_tag, in_ready); end
    tick();
    in_valid = 0;
  endtask

  task automatic test_protocol_error();
    do_reset();
    fpu_resp_valid = 1; fpu_resp_bits_tag = 5; tick();
    fpu_resp_valid = 0; #1;
    checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL err_set: got %0b expected 1", err_unexpected); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_no_out: got %0b/%0b expected 0/0", out_valid, busy); end
    tick(); tick(); tick(); #1;
    checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b expected 1", err_unexpected); end
    do_reset(); #1;
    checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL err_cleared: got %0b expected 0", err_unexpected); end
    issue_ops(1, 8'h71);
    fpu_resp_valid = 1; fpu_resp_bits_tag = 0; fpu_resp_bits_result = lanes(32'h71); tick();
    fpu_resp_bits_result = lanes(32'hDEAD); tick();
    fpu_resp_valid = 0; #1;
    checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL err_double: got %0b expected 1", err_unexpected); end
    checks++; if (out_valid !== 1'b1 || out_bits_result !== lanes(32'h71)) begin errors++; $display("FAIL err_double_kept: got %0b %0h expected 1/71", out_valid, out_bits_result[31:0]); end
  endtask

  task automatic test_random();
    int pend[$];
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom()); in_bits_id = IW'($urandom()); in_bits_op = 5'($urandom());
      in_bits_operands_0 = rand_wide(); in_bits_simdMask = 16'($urandom());
      fpu_req_ready = ($urandom() % 4) != 0; out_ready = 1'($urandom()); flush = ($urandom() % 50) == 0;
      pend.delete();
      foreach (q[i]) if (!q[i].done) pend.push_back(i);
      fpu_resp_valid = 0;
      if (pend.size() > 0 && ($urandom() % 2) == 1) begin
        fpu_resp_valid = 1;
        fpu_resp_bits_tag = q[pend[$urandom() % pend.size()]].tag;
        fpu_resp_bits_result = rand_wide(); fpu_resp_bits_status = 5'($urandom());
      end
      #1;
      checks++; if (in_ready !== m_in_ready() || fpu_req_valid !== m_req_valid())
        begin errors++; $display("FAIL rand_issue c%0d: got %0b/%0b expected %0b/%0b", c, in_ready, fpu_req_valid, m_in_ready(), m_req_valid()); end
      if (in_valid) begin
        checks++; if (fpu_req_bits_tag !== TW'(next_tag)) begin errors++; $display("FAIL rand_tag c%0d: got %0d expected %0d", c, fpu_req_bits_tag, next_tag); end
      end
      checks++; if (out_valid !== m_out_valid()) begin errors++; $display("FAIL rand_out_valid c%0d: got %0b expected %0b", c, out_valid, m_out_valid()); end
      if (m_out_valid()) begin
        checks++; if (out_bits_id !== q[0].id || out_bits_result !== q[0].result || out_bits_status !== q[0].status)
          begin errors++; $display("FAIL rand_out_bits c%0d: got id %0h st %0d expected id %0h st %0d", c, out_bits_id, out_bits_status, q[0].id, q[0].status); end
      end
      checks++; if (busy !== (q.size() != 0) || err_unexpected !== m_err || fpu_flush !== flush)
        begin errors++; $display("FAIL rand_status c%0d: got busy %0b err %0b expected %0b/%0b", c, busy, err_unexpected, q.size() != 0, m_err); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 1;
    @(negedge clock);
    test_reset();
    test_single_op();
    test_out_of_order();
    test_full_wrap();
    test_back_to_back();
    test_flush();
    test_protocol_error();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
